req_encoder: RTL and testbench
==============================

REQ_ENCODER -- requirements
Module: req_encoder

Interface
REQ-001: Parameter N, default 8: number of request inputs; legal range 2..64, non-power-of-two allowed.
REQ-002: Parameter MODE, default 0: 0 selects fixed priority (highest index wins); 1 selects round-robin.
REQ-003: Derived constant W = ceil(log2(N)) sets index width; it is not user-overridable.
REQ-004: clk  input  1  sole clock; all state changes on the rising edge.
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: req  input  N  request lines; bit k corresponds to index k.
REQ-007: out_valid  output  1  out_idx and out_multi hold a pending result.
REQ-008: out_ready  input  1  consumer accepts the result when high together with out_valid.
REQ-009: out_idx  output  W  encoded index of the selected request.
REQ-010: out_multi  output  1  more than one req bit was set when the result was captured.

Function
REQ-011: The output register is "free" when out_valid=0 or when out_valid=1 and out_ready=1 in the same cycle.
REQ-012: When the register is free and req is non-zero, the block loads on that edge: out_valid=1, out_idx=selected index, out_multi=(popcount(req)>1).
REQ-013: When the register is free and req is zero, the block loads out_valid=0 on that edge; out_idx and out_multi hold their previous values.
REQ-014: When out_valid=1 and out_ready=0, out_valid, out_idx and out_multi shall hold stable; req changes are ignored.
REQ-015: Latency from a req sample to out_valid is exactly 1 cycle; a back-to-back accept-and-reload gives one result per cycle.
REQ-016: In MODE 0, the selected index is the highest set bit of req.
REQ-017: In MODE 1, the search starts at pointer ptr (W bits) and ascends modulo N; the first set bit found is selected.
REQ-018: In MODE 1, ptr updates to (selected+1) mod N on every load with non-zero req; otherwise ptr holds.
REQ-019: ptr shall wrap from N-1 to 0; ptr and out_idx shall never hold a value >= N.
REQ-020: In MODE 0, ptr is unused and may be optimised away.
REQ-021: out_ready while out_valid=0 has no effect.

Reset
REQ-022: While rst=1, out_valid=0, out_idx=0, out_multi=0 and ptr=0, immediately and independent of clk.
REQ-023: Assertion of rst mid-transfer discards the pending result without handshake.
REQ-024: On the first edge after rst deasserts, the register is free; a non-zero req then loads per REQ-012.

Structure
REQ-025: Shared package encoder_pkg holds the MODE_FIXED=0 and MODE_RR=1 constants and the clog2 helper function.
REQ-026: Selection logic shall live in one combinational sub-module, prio_pick.
REQ-027: prio_pick ports: req[N], start[W], found, idx[W].
REQ-028: In MODE 0, prio_pick is used with start tied so that it searches from the top.

Verification
REQ-029: MODE 0, N=8: req=8'b0000_1000 with out_ready=1 -> next cycle out_valid=1, out_idx=3, out_multi=0.
REQ-030: MODE 0, N=8: req=8'b1010_0010 -> out_idx=7, out_multi=1.
REQ-031: MODE 0, req=8'h01 with out_ready=0 for 5 cycles while req changes to 8'h80 -> out_idx stays 0 and out_valid stays 1; when out_ready rises, the next cycle shows out_idx=7.
REQ-032: MODE 1, N=8: req=8'hFF held with out_ready=1 for 10 cycles -> out_idx sequence 0,1,2,...,7,0,1 (wrap).
REQ-033: MODE 1, N=5: req=5'b10001, ptr=4 -> out_idx=4, then 0, then 4; out_idx never reaches 5..7.
REQ-034: Assert rst asynchronously mid-cycle while out_valid=1 -> out_valid=0 and out_idx=0 before the next edge; after release, req=0 keeps out_valid=0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the request encoder slice.
//   MODE_FIXED / MODE_RR : selection mode encodings
//   clog2()              : ceiling log2, used to size index fields
package encoder_pkg;

   localparam int unsigned MODE_FIXED = 0;
   localparam int unsigned MODE_RR    = 1;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/req_encoder_prio_pick.sv
// Combinational circular priority picker.
//   req   : request vector, bit k is index k
//   start : index where the search begins (must be < N)
//   found : at least one request bit is set
//   idx   : first set bit at or above start, wrapping modulo N
module prio_pick
   import encoder_pkg::*;
#(
   parameter  int unsigned N = 8,
   localparam int unsigned W = clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);

   // One extra bit so start + offset never overflows before the wrap.
   localparam int unsigned WP = W + 1;

   logic [WP-1:0] pos;
   logic [W-1:0]  pos_w;

   // Ascending scan from start; the first hit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      pos_w = '0;
      for (int i = 0; i < int'(N); i++) begin
         pos = {1'b0, start} + WP'(i);
         if (pos >= WP'(N)) pos = pos - WP'(N);
         pos_w = W'(pos);
         if (!found && req[pos_w]) begin
            found = 1'b1;
            idx   = pos_w;
         end
      end
   end

endmodule

// File: rtl/req_encoder.sv
// Request encoder with a registered, ready/valid-handshaked result.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : N request lines
//   out_valid : a result is pending in the output register
//   out_ready : consumer accepts the pending result
//   out_idx   : selected index (highest set bit, or round-robin pick)
//   out_multi : more than one request was set at capture
module req_encoder
   import encoder_pkg::*;
#(
   parameter  int unsigned N    = 8,
   parameter  int unsigned MODE = MODE_FIXED,
   localparam int unsigned W    = clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_multi
);

   logic [W-1:0] ptr;
   logic [N-1:0] pick_req;
   logic [W-1:0] pick_start;
   logic [W-1:0] pick_idx;
   logic         pick_found;
   logic [W-1:0] sel;
   logic [W-1:0] next_ptr;
   logic         multi;
   logic         load;

   // Fixed priority reuses the ascending picker on the bit-reversed vector
   // starting at 0, so its first hit is the highest original index.
   always_comb begin
      pick_req   = req;
      pick_start = ptr;
      if (MODE != MODE_RR) begin
         pick_req   = {<<{req}};
         pick_start = '0;
      end
   end

   prio_pick #(.N(N)) u_pick (
      .req   (pick_req),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Selected index in original numbering, plus derived flags.
   always_comb begin
      sel      = (MODE == MODE_RR) ? pick_idx : (W'(N - 1) - pick_idx);
      next_ptr = (sel == W'(N - 1)) ? '0 : (sel + W'(1));
      multi    = |(req & (req - N'(1)));
      load     = !out_valid || out_ready;
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_multi <= 1'b0;
         ptr       <= '0;
      end else if (load) begin
         out_valid <= pick_found;
         if (pick_found) begin
            out_idx   <= sel;
            out_multi <= multi;
            if (MODE == MODE_RR) ptr <= next_ptr;
         end
      end
   end

endmodule

// File: tb/tb_req_encoder.sv
// Self-checking bench: fixed-priority N=8, round-robin N=8 and N=5 instances.
module tb_req_encoder;

   typedef struct {
      int   idx;
      logic multi;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [7:0] req_a = '0;
   logic       ready_a = 1'b0, valid_a, multi_a;
   logic [2:0] idx_a;

   logic [7:0] req_b = '0;
   logic       ready_b = 1'b0, valid_b, multi_b;
   logic [2:0] idx_b;

   logic [4:0] req_c = '0;
   logic       ready_c = 1'b0, valid_c, multi_c;
   logic [2:0] idx_c;

   int n_checks = 0;
   int n_errors = 0;
   int pb = 0;
   int pc = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   always #5 clk = ~clk;

   req_encoder #(.N(8), .MODE(0)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .out_valid(valid_a),
      .out_ready(ready_a), .out_idx(idx_a), .out_multi(multi_a));

   req_encoder #(.N(8), .MODE(1)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .out_valid(valid_b),
      .out_ready(ready_b), .out_idx(idx_b), .out_multi(multi_b));

   req_encoder #(.N(5), .MODE(1)) dut_c (
      .clk(clk), .rst(rst), .req(req_c), .out_valid(valid_c),
      .out_ready(ready_c), .out_idx(idx_c), .out_multi(multi_c));

   function automatic int hi_idx(input logic [63:0] r, input int n);
      int h = 0;
      for (int k = 0; k < n; k++) if (r[k]) h = k;
      return h;
   endfunction

   function automatic logic multi_of(input logic [63:0] r, input int n);
      int c = 0;
      for (int k = 0; k < n; k++) if (r[k]) c++;
      return c > 1;
   endfunction

   function automatic int rr_pick(input logic [63:0] r, input int n, input int p);
      for (int i = 0; i < n; i++) if (r[(p + i) % n]) return (p + i) % n;
      return 0;
   endfunction

   task automatic test_reset();
      #1;
      n_checks++;
      if ({valid_a, idx_a, multi_a} !== 5'b0)
         begin n_errors++; $display("FAIL reset_a: got %b expected 00000", {valid_a, idx_a, multi_a}); end
      n_checks++;
      if ({valid_b, idx_b, multi_b, valid_c, idx_c, multi_c} !== 10'b0)
         begin n_errors++; $display("FAIL reset_bc: got %b expected 0", {valid_b, idx_b, multi_b, valid_c, idx_c, multi_c}); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fixed_patterns();
      logic [7:0] pats [6] = '{8'h08, 8'hA2, 8'h01, 8'h80, 8'hFF, 8'h06};
      exp_t e, last;
      last = '{idx: 0, multi: 1'b0};
      ready_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_a = pats[i];
         q_a.push_back('{idx: hi_idx(64'(pats[i]), 8), multi: multi_of(64'(pats[i]), 8)});
         @(posedge clk); #1;
         n_checks++;
         if (valid_a !== 1'b1) begin n_errors++; $display("FAIL fixed_valid[%0d]: got %b expected 1", i, valid_a); end
         n_checks++;
         if (q_a.size() == 0) begin n_errors++; $display("FAIL fixed_sb[%0d]: got empty queue expected entry", i); end
         else begin
            e = q_a.pop_front();
            last = e;
            if (idx_a !== 3'(e.idx) || multi_a !== e.multi) begin
               n_errors++;
               $display("FAIL fixed_out[%0d]: got idx=%0d multi=%b expected idx=%0d multi=%b", i, idx_a, multi_a, e.idx, e.multi);
            end
         end
      end
      req_a = '0;
      @(posedge clk); #1;
      n_checks++;
      if (valid_a !== 1'b0 || idx_a !== 3'(last.idx) || multi_a !== last.multi)
         begin n_errors++; $display("FAIL fixed_zero: got v=%b idx=%0d m=%b expected v=0 idx=%0d m=%b", valid_a, idx_a, multi_a, last.idx, last.multi); end
   endtask

   task automatic test_backpressure();
      exp_t e;
      req_a = 8'h01; ready_a = 1'b0;
      q_a.push_back('{idx: 0, multi: 1'b0});
      @(posedge clk); #1;
      req_a = 8'h80;
      n_checks++;
      e = q_a.pop_front();
      if (valid_a !== 1'b1 || idx_a !== 3'(e.idx) || multi_a !== e.multi)
         begin n_errors++; $display("FAIL bp_first: got v=%b idx=%0d expected v=1 idx=%0d", valid_a, idx_a, e.idx); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (valid_a !== 1'b1 || idx_a !== 3'd0 || multi_a !== 1'b0)
            begin n_errors++; $display("FAIL bp_hold[%0d]: got v=%b idx=%0d expected v=1 idx=0", i, valid_a, idx_a); end
      end
      ready_a = 1'b1;
      q_a.push_back('{idx: hi_idx(64'(req_a), 8), multi: multi_of(64'(req_a), 8)});
      @(posedge clk); #1;
      n_checks++;
      e = q_a.pop_front();
      if (valid_a !== 1'b1 || idx_a !== 3'(e.idx))
         begin n_errors++; $display("FAIL bp_release: got v=%b idx=%0d expected v=1 idx=%0d", valid_a, idx_a, e.idx); end
      req_a = '0;
      @(posedge clk); #1;
      n_checks++;
      if (valid_a !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got v=%b expected 0", valid_a); end
   endtask

   task automatic test_rr_wrap();
      exp_t e;
      int   k;
      ready_b = 1'b1;
      req_b = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         k = rr_pick(64'(req_b), 8, pb);
         q_b.push_back('{idx: k, multi: 1'b1});
         pb = (k + 1) % 8;
         @(posedge clk); #1;
         n_checks++;
         if (q_b.size() == 0) begin n_errors++; $display("FAIL rr8_sb[%0d]: got empty queue expected entry", i); end
         else begin
            e = q_b.pop_front();
            if (valid_b !== 1'b1 || idx_b !== 3'(e.idx) || multi_b !== e.multi)
               begin n_errors++; $display("FAIL rr8[%0d]: got v=%b idx=%0d m=%b expected v=1 idx=%0d m=%b", i, valid_b, idx_b, multi_b, e.idx, e.multi); end
         end
         // Sequence must be 0..7 then wrap to 0,1.
         n_checks++;
         if (e.idx != i % 8) begin n_errors++; $display("FAIL rr8_seq[%0d]: got %0d expected %0d", i, e.idx, i % 8); end
      end
      req_b = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_rr_n5();
      logic [4:0] pats [4] = '{5'b01000, 5'b10001, 5'b10001, 5'b10001};
      exp_t e;
      int   k;
      ready_c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_c = pats[i];
         k = rr_pick(64'(req_c), 5, pc);
         q_c.push_back('{idx: k, multi: multi_of(64'(req_c), 5)});
         pc = (k + 1) % 5;
         @(posedge clk); #1;
         n_checks++;
         e = q_c.pop_front();
         if (valid_c !== 1'b1 || idx_c !== 3'(e.idx) || multi_c !== e.multi)
            begin n_errors++; $display("FAIL rr5[%0d]: got v=%b idx=%0d m=%b expected v=1 idx=%0d m=%b", i, valid_c, idx_c, multi_c, e.idx, e.multi); end
         n_checks++;
         if (idx_c >= 3'd5) begin n_errors++; $display("FAIL rr5_range[%0d]: got %0d expected <5", i, idx_c); end
      end
      req_c = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      exp_t e;
      req_a = 8'h02; ready_a = 1'b0;
      q_a.push_back('{idx: 1, multi: 1'b0});
      @(posedge clk); #1;
      n_checks++;
      e = q_a.pop_front();
      if (valid_a !== 1'b1 || idx_a !== 3'(e.idx))
         begin n_errors++; $display("FAIL arst_pre: got v=%b idx=%0d expected v=1 idx=%0d", valid_a, idx_a, e.idx); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({valid_a, idx_a, multi_a} !== 5'b0)
         begin n_errors++; $display("FAIL arst_now: got %b expected 00000", {valid_a, idx_a, multi_a}); end
      q_a.delete(); q_b.delete(); q_c.delete();
      pb = 0; pc = 0;
      req_a = '0; ready_a = 1'b1;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (valid_a !== 1'b0) begin n_errors++; $display("FAIL arst_idle: got v=%b expected 0", valid_a); end
      req_a = 8'h10;
      req_c = 5'b10001; ready_c = 1'b1;
      q_a.push_back('{idx: hi_idx(64'(req_a), 8), multi: 1'b0});
      q_c.push_back('{idx: rr_pick(64'(req_c), 5, pc), multi: 1'b1});
      @(posedge clk); #1;
      n_checks++;
      e = q_a.pop_front();
      if (valid_a !== 1'b1 || idx_a !== 3'(e.idx) || multi_a !== e.multi)
         begin n_errors++; $display("FAIL arst_reload_a: got v=%b idx=%0d expected v=1 idx=%0d", valid_a, idx_a, e.idx); end
      n_checks++;
      e = q_c.pop_front();
      if (valid_c !== 1'b1 || idx_c !== 3'(e.idx))
         begin n_errors++; $display("FAIL arst_reload_c: got v=%b idx=%0d expected v=1 idx=%0d", valid_c, idx_c, e.idx); end
      req_a = '0; req_c = '0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_fixed_patterns();
      test_backpressure();
      test_rr_wrap();
      test_rr_n5();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
